// File: rtl/memory_controller_if.sv
// Request, completion and RAM-side signals of memory_controller, bundled with
// a controller-side (slave) and an environment-side (master) view.
interface memory_controller_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  LSBMC_en;
   logic                  LSBMC_wr;
   logic [2:0]            LSBMC_data_width;
   logic [ADDR_WIDTH-1:0] LSBMC_addr;
   logic [31:0]           LSBMC_data;
   logic                  MCLSB_r_en;
   logic                  MCLSB_w_en;
   logic [31:0]           MCLSB_data;
   logic                  ICMC_en;
   logic [ADDR_WIDTH-1:0] ICMC_addr;
   logic                  MCIC_en;
   logic [31:0]           MCIC_data;
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;
   logic                  io_buffer_full;

   modport slave (
      input  LSBMC_en, LSBMC_wr, LSBMC_data_width, LSBMC_addr, LSBMC_data,
      output MCLSB_r_en, MCLSB_w_en, MCLSB_data,
      input  ICMC_en, ICMC_addr,
      output MCIC_en, MCIC_data,
      input  mem_din,
      output mem_dout, mem_a, mem_wr,
      input  io_buffer_full
   );

   modport master (
      output LSBMC_en, LSBMC_wr, LSBMC_data_width, LSBMC_addr, LSBMC_data,
      input  MCLSB_r_en, MCLSB_w_en, MCLSB_data,
      output ICMC_en, ICMC_addr,
      input  MCIC_en, MCIC_data,
      output mem_din,
      input  mem_dout, mem_a, mem_wr,
      output io_buffer_full
   );
endinterface

// File: rtl/memory_controller.sv
// Byte-serial RAM port arbiter: LSB loads/stores have priority over 4-byte
// instruction fetches; reads are pipelined against the one-cycle RAM latency.
module memory_controller #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_ADDR_LO = 'h30000,
   parameter logic [ADDR_WIDTH-1:0] IO_ADDR_HI = 'h30007
) (
   input  logic                Sys_clk,
   input  logic                Sys_rst,
   input  logic                Sys_rdy,
   input  logic                RoBMC_pre_judge,
   memory_controller_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, IF_READ, LS_READ, LS_WRITE, DONE} state_t;

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] base_reg;
   logic [ADDR_WIDTH-1:0] mem_a_reg;
   logic [2:0]            width_reg;
   logic [2:0]            cnt_reg;
   logic [2:0]            cap_reg;
   logic [31:0]           wdata_reg;
   logic [31:0]           asm_reg;
   logic [31:0]           lsb_data_reg;
   logic [31:0]           ic_data_reg;
   logic [7:0]            mem_dout_reg;
   logic                  mem_wr_reg;
   logic                  r_en_reg;
   logic                  w_en_reg;
   logic                  ic_en_reg;
   logic                  lag1_reg;
   logic                  lag2_reg;

   logic                  flush;
   logic                  accept_write;
   logic [ADDR_WIDTH-1:0] accept_addr;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic                  accept_stall;
   logic                  issue_stall;
   logic                  issue_more;
   logic [31:0]           merged;

   function automatic logic in_io(input logic [ADDR_WIDTH-1:0] a);
      return (a >= IO_ADDR_LO) && (a <= IO_ADDR_HI);
   endfunction

   assign flush        = ~RoBMC_pre_judge;
   assign accept_write = bus.LSBMC_en & bus.LSBMC_wr;
   assign accept_addr  = bus.LSBMC_en ? bus.LSBMC_addr : bus.ICMC_addr;
   assign issue_addr   = base_reg + ADDR_WIDTH'(cnt_reg);
   assign accept_stall = bus.io_buffer_full & in_io(accept_addr);
   assign issue_stall  = bus.io_buffer_full & in_io(issue_addr);
   assign issue_more   = cnt_reg < width_reg;

   // Assembled word as it will look once the byte now on mem_din is merged in.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[gi*8 +: 8] = (cap_reg[1:0] == 2'(gi)) ? bus.mem_din
                                                             : asm_reg[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge Sys_clk or negedge Sys_rst) begin
      if (!Sys_rst) begin
         state_reg    <= IDLE;
         base_reg     <= '0;
         mem_a_reg    <= '0;
         width_reg    <= '0;
         cnt_reg      <= '0;
         cap_reg      <= '0;
         wdata_reg    <= '0;
         asm_reg      <= '0;
         lsb_data_reg <= '0;
         ic_data_reg  <= '0;
         mem_dout_reg <= '0;
         mem_wr_reg   <= 1'b0;
         r_en_reg     <= 1'b0;
         w_en_reg     <= 1'b0;
         ic_en_reg    <= 1'b0;
         lag1_reg     <= 1'b0;
         lag2_reg     <= 1'b0;
      end else if (!Sys_rdy) begin
         // Frozen: no write strobe, and a pulse already given is not repeated.
         mem_wr_reg <= 1'b0;
         r_en_reg   <= 1'b0;
         w_en_reg   <= 1'b0;
         ic_en_reg  <= 1'b0;
      end else begin
         r_en_reg  <= 1'b0;
         w_en_reg  <= 1'b0;
         ic_en_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               mem_wr_reg <= 1'b0;
               if (!flush && (bus.LSBMC_en || bus.ICMC_en)) begin
                  base_reg  <= accept_addr;
                  width_reg <= bus.LSBMC_en ? bus.LSBMC_data_width : 3'd4;
                  wdata_reg <= bus.LSBMC_data;
                  asm_reg   <= '0;
                  cap_reg   <= '0;
                  lag2_reg  <= 1'b0;
                  if (accept_stall) begin
                     cnt_reg  <= '0;
                     lag1_reg <= 1'b0;
                  end else begin
                     cnt_reg    <= 3'd1;
                     mem_a_reg  <= accept_addr;
                     lag1_reg   <= ~accept_write;
                     mem_wr_reg <= accept_write;
                     if (accept_write)
                        mem_dout_reg <= bus.LSBMC_data[7:0];
                  end
                  if (!bus.LSBMC_en)
                     state_reg <= IF_READ;
                  else if (bus.LSBMC_wr)
                     state_reg <= LS_WRITE;
                  else
                     state_reg <= LS_READ;
               end
            end

            IF_READ, LS_READ: begin
               if (state_reg == IF_READ && flush) begin
                  state_reg <= IDLE;
               end else begin
                  // lag1: address went out last edge; lag2: its byte is on mem_din now.
                  lag2_reg <= lag1_reg;
                  lag1_reg <= 1'b0;
                  if (issue_more && !issue_stall) begin
                     mem_a_reg <= issue_addr;
                     cnt_reg   <= cnt_reg + 3'd1;
                     lag1_reg  <= 1'b1;
                  end
                  if (lag2_reg) begin
                     asm_reg <= merged;
                     cap_reg <= cap_reg + 3'd1;
                     if (cap_reg == width_reg - 3'd1) begin
                        if (state_reg == IF_READ) begin
                           ic_data_reg <= merged;
                           ic_en_reg   <= 1'b1;
                        end else begin
                           lsb_data_reg <= merged;
                           r_en_reg     <= 1'b1;
                        end
                        state_reg <= DONE;
                     end
                  end
               end
            end

            LS_WRITE: begin
               if (issue_more) begin
                  if (issue_stall) begin
                     mem_wr_reg <= 1'b0;
                  end else begin
                     mem_a_reg    <= issue_addr;
                     mem_dout_reg <= wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
                     mem_wr_reg   <= 1'b1;
                     cnt_reg      <= cnt_reg + 3'd1;
                  end
               end else begin
                  mem_wr_reg <= 1'b0;
                  w_en_reg   <= 1'b1;
                  state_reg  <= DONE;
               end
            end

            DONE: begin
               mem_wr_reg <= 1'b0;
               state_reg  <= IDLE;
            end

            default: begin
               mem_wr_reg <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_a      = mem_a_reg;
   assign bus.mem_dout   = mem_dout_reg;
   assign bus.mem_wr     = mem_wr_reg;
   assign bus.MCLSB_r_en = r_en_reg;
   assign bus.MCLSB_w_en = w_en_reg;
   assign bus.MCLSB_data = lsb_data_reg;
   assign bus.MCIC_en    = ic_en_reg;
   assign bus.MCIC_data  = ic_data_reg;
endmodule

// File: tb/tb_memory_controller.sv
// Directed and random transactions against memory_controller with a byte-array
// reference of RAM contents and latency rules computed from widths and stalls.
module tb_memory_controller;
   logic clk;
   logic rst_n;
   logic rdy;
   logic pre_judge;

   memory_controller_if #(.ADDR_WIDTH(32)) bus ();

   memory_controller #(
      .ADDR_WIDTH (32),
      .IO_ADDR_LO (32'h30000),
      .IO_ADDR_HI (32'h30007)
   ) dut (
      .Sys_clk         (clk),
      .Sys_rst         (rst_n),
      .Sys_rdy         (rdy),
      .RoBMC_pre_judge (pre_judge),
      .bus             (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] ram [0:65535];
   logic [7:0] mdl [0:65535];
   logic       ram_ready = 1'b0;
   int         wr_count = 0;
   int         ic_pulses = 0;
   int         lsb_pulses = 0;

   function automatic logic [7:0] init_byte(input int a);
      return 8'((a * 37 + 5) ^ (a >>> 8));
   endfunction

   // Behavioural RAM: one-cycle read latency, write on the edge with mem_wr high.
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
         ram_ready <= 1'b1;
      end else if (bus.mem_wr) begin
         ram[bus.mem_a[15:0]] <= bus.mem_dout;
         wr_count <= wr_count + 1;
      end
      bus.mem_din <= ram[bus.mem_a[15:0]];
   end

   always @(negedge clk) begin
      if (bus.MCIC_en) ic_pulses <= ic_pulses + 1;
      if (bus.MCLSB_r_en || bus.MCLSB_w_en) lsb_pulses <= lsb_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] addr, input int w);
      logic [31:0] r;
      logic [31:0] a;
      r = '0;
      for (int k = 0; k < w; k++) begin
         a = addr + 32'(k);
         r[k*8 +: 8] = mdl[a[15:0]];
      end
      return r;
   endfunction

   // Called just after a rising edge with the controller idle.
   task automatic lsb_op(input bit wr, input int w, input logic [31:0] addr,
                         input logic [31:0] data, input int full_cycles,
                         input int exp_extra, input int flush_at, input string tag);
      int n;
      bit got;
      int wr_hi;
      int wc0;
      logic [31:0] exp_data;
      logic [31:0] a;
      exp_data = model_word(addr, w);
      bus.LSBMC_en = 1'b1;
      bus.LSBMC_wr = wr;
      bus.LSBMC_data_width = 3'(w);
      bus.LSBMC_addr = addr;
      bus.LSBMC_data = data;
      bus.io_buffer_full = (full_cycles > 0);
      pre_judge = (flush_at != 0);
      wc0 = wr_count;
      n = 0;
      got = 1'b0;
      wr_hi = 0;
      while (!got && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.mem_wr) wr_hi++;
         bus.io_buffer_full = (n < full_cycles);
         pre_judge = (flush_at != n);
         got = bus.MCLSB_r_en | bus.MCLSB_w_en;
      end
      check({tag, "_latency"}, 32'(n - 1), 32'((wr ? w : w + 1) + exp_extra));
      check({tag, "_kind"}, {30'd0, bus.MCLSB_r_en, bus.MCLSB_w_en}, wr ? 32'd1 : 32'd2);
      check({tag, "_write_cycles"}, 32'(wr_hi), wr ? 32'(w) : 32'd0);
      if (wr) begin
         for (int k = 0; k < w; k++) begin
            a = addr + 32'(k);
            mdl[a[15:0]] = data[k*8 +: 8];
         end
         check({tag, "_ram_writes"}, 32'(wr_count - wc0), 32'(w));
      end else begin
         check({tag, "_data"}, bus.MCLSB_data, exp_data);
      end
      bus.LSBMC_en = 1'b0;
      bus.io_buffer_full = 1'b0;
      pre_judge = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_pulse_width"}, {30'd0, bus.MCLSB_r_en, bus.MCLSB_w_en}, 32'd0);
      for (int k = 0; k <= w; k++) begin
         a = addr + 32'(k);
         check({tag, "_ram_byte"}, {24'd0, ram[a[15:0]]}, {24'd0, mdl[a[15:0]]});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_op(input logic [31:0] addr, input string tag);
      int n;
      bit got;
      logic [31:0] exp_data;
      exp_data = model_word(addr, 4);
      bus.ICMC_en = 1'b1;
      bus.ICMC_addr = addr;
      n = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         got = bus.MCIC_en;
      end
      check({tag, "_latency"}, 32'(n - 1), 32'd5);
      check({tag, "_data"}, bus.MCIC_data, exp_data);
      bus.ICMC_en = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_pulse_width"}, {31'd0, bus.MCIC_en}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit got;
      int p0;
      logic [31:0] exp_word;

      for (int i = 0; i < 65536; i++) mdl[i] = init_byte(i);
      rst_n = 1'b0;
      rdy = 1'b1;
      pre_judge = 1'b1;
      bus.LSBMC_en = 1'b0;
      bus.LSBMC_wr = 1'b0;
      bus.LSBMC_data_width = 3'd0;
      bus.LSBMC_addr = '0;
      bus.LSBMC_data = '0;
      bus.ICMC_en = 1'b0;
      bus.ICMC_addr = '0;
      bus.io_buffer_full = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_mem_a", bus.mem_a, 32'd0);
      check("reset_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("reset_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
      check("reset_pulses", {29'd0, bus.MCLSB_r_en, bus.MCLSB_w_en, bus.MCIC_en}, 32'd0);
      check("reset_lsb_data", bus.MCLSB_data, 32'd0);
      check("reset_ic_data", bus.MCIC_data, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic store/load of each width, including a neighbour left untouched.
      lsb_op(1'b1, 4, 32'h1000, 32'h44332211, 0, 0, -1, "sw_1000");
      lsb_op(1'b0, 4, 32'h1000, 32'h0, 0, 0, -1, "lw_1000");
      lsb_op(1'b1, 2, 32'h2002, 32'hABCD1234, 0, 0, -1, "sh_2002");
      lsb_op(1'b0, 2, 32'h2002, 32'h0, 0, 0, -1, "lh_2002");
      lsb_op(1'b1, 1, 32'h10, 32'h00000080, 0, 0, -1, "sb_10");

      // Simultaneous requests: the load wins, the fetch follows after DONE.
      bus.ICMC_en = 1'b1;
      bus.ICMC_addr = 32'h1000;
      exp_word = model_word(32'h1000, 4);
      lsb_op(1'b0, 1, 32'h10, 32'h0, 0, 0, -1, "lb_contend");
      n = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         got = bus.MCIC_en;
      end
      check("fetch_after_lsb_delay", 32'(n), 32'd5);
      check("fetch_after_lsb_data", bus.MCIC_data, exp_word);
      bus.ICMC_en = 1'b0;
      @(posedge clk);
      #1;
      check("fetch_after_lsb_pulse_width", {31'd0, bus.MCIC_en}, 32'd0);
      @(posedge clk);
      #1;

      // Flushed fetch: no pulse, and a load is accepted on the very next edge.
      p0 = ic_pulses;
      bus.ICMC_en = 1'b1;
      bus.ICMC_addr = 32'h0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      pre_judge = 1'b0;
      bus.ICMC_en = 1'b0;
      @(posedge clk);
      #1;
      pre_judge = 1'b1;
      lsb_op(1'b0, 4, 32'h1000, 32'h0, 0, 0, -1, "lw_after_flush");
      check("flushed_fetch_no_pulse", 32'(ic_pulses - p0), 32'd0);

      // Flush mid-load is ignored; flush in IDLE delays acceptance by one edge.
      lsb_op(1'b0, 4, 32'h1000, 32'h0, 0, 0, 2, "lw_flush_mid");
      lsb_op(1'b0, 2, 32'h2002, 32'h0, 0, 1, 0, "lh_flush_idle");

      // I/O stalls and their address boundaries.
      lsb_op(1'b1, 1, 32'h30000, 32'h0000005A, 3, 3, -1, "sb_io_stall");
      lsb_op(1'b1, 1, 32'h30007, 32'h000000C3, 2, 2, -1, "sb_io_hi");
      lsb_op(1'b1, 1, 32'h30008, 32'h0000003C, 2, 0, -1, "sb_above_io");
      lsb_op(1'b1, 1, 32'h2000, 32'h00000011, 3, 0, -1, "sb_full_not_io");
      lsb_op(1'b1, 2, 32'h2FFFF, 32'h0000BEEF, 2, 1, -1, "sh_into_io");

      // Address wrap at 2^32 and a plain fetch.
      lsb_op(1'b1, 4, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 0, -1, "sw_wrap");
      lsb_op(1'b0, 4, 32'hFFFFFFFE, 32'h0, 0, 0, -1, "lw_wrap");
      fetch_op(32'h1000, "fetch_1000");

      // Asynchronous reset in the middle of a load.
      p0 = lsb_pulses;
      bus.LSBMC_en = 1'b1;
      bus.LSBMC_wr = 1'b0;
      bus.LSBMC_data_width = 3'd4;
      bus.LSBMC_addr = 32'h1000;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_mem_a", bus.mem_a, 32'd0);
      check("midrst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("midrst_lsb_data", bus.MCLSB_data, 32'd0);
      check("midrst_ic_data", bus.MCIC_data, 32'd0);
      bus.LSBMC_en = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("midrst_no_stray_pulse", 32'(lsb_pulses - p0), 32'd0);
      lsb_op(1'b0, 4, 32'h1000, 32'h0, 0, 0, -1, "lw_after_reset");

      // Random mix of loads, stores and fetches.
      for (int i = 0; i < 30; i++) begin
         int kind;
         int w;
         logic [31:0] addr;
         kind = int'($urandom_range(0, 2));
         w = 1 << $urandom_range(0, 2);
         addr = 32'h100 + 32'($urandom_range(0, 63));
         if (kind == 2)
            fetch_op(addr, "rnd_fetch");
         else
            lsb_op(kind == 1, w, addr, $urandom, int'($urandom_range(0, 2)), 0, -1,
                   kind == 1 ? "rnd_store" : "rnd_load");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
